// File: rtl/mem_resp_pkg.sv
// Shared definitions for the main-memory responder.
// Latency: n/a (types, defaults and a helper function only).
// Backpressure: n/a.
//
// Contents: default widths/latency, word-index width helper, and the
// default pipeline-stage record {valid, addr, data}.
package mem_resp_pkg;

  localparam int DWIDTH_DEF      = 16;
  localparam int AWIDTH_DEF      = 16;
  localparam int DEPTH_WORDS_DEF = 1024;
  localparam int LATENCY_DEF     = 4;

  // Number of address bits that select a word (byte bit 0 excluded).
  function automatic int idx_width(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

  // One slot of the read-response delay line at default widths.
  typedef struct packed {
    logic                  valid;
    logic [AWIDTH_DEF-1:0] addr;
    logic [DWIDTH_DEF-1:0] data;
  } stage_t;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Generic valid/addr/data delay line for read responses.
// Latency: LATENCY cycles from in_stage to out_stage (registered output).
// Backpressure: none; one entry may enter every cycle.
//
// Ports:
//   clk       - rising-edge clock
//   flush_n   - synchronous active-low flush; zeroes every stage
//   in_stage  - entry launched this cycle (valid qualifies addr/data)
//   out_stage - last stage; addr/data hold their last valid values
import mem_resp_pkg::*;

module mem_rsp_pipe #(
  parameter int  LATENCY    = LATENCY_DEF,
  parameter type stage_type = stage_t
) (
  input  logic      clk,
  input  logic      flush_n,
  input  stage_type in_stage,
  output stage_type out_stage
);

  stage_type stg [LATENCY];

  // Payload only moves with a valid entry, so every stage (and in
  // particular the last one) keeps the most recent valid addr/data while
  // bubbles pass through it.
  always_ff @(posedge clk) begin
    if (!flush_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0].valid <= in_stage.valid;
      if (in_stage.valid) begin
        stg[0].addr <= in_stage.addr;
        stg[0].data <= in_stage.data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        stg[i].valid <= stg[i-1].valid;
        if (stg[i-1].valid) begin
          stg[i].addr <= stg[i-1].addr;
          stg[i].data <= stg[i-1].data;
        end
      end
    end
  end

  assign out_stage = stg[LATENCY-1];

endmodule

// File: rtl/mem_multicycle_resp.sv
// Main-memory responder: single-cycle write commit, pipelined reads.
// Latency: write commits at the accepting edge; read data LATENCY cycles later.
// Backpressure: none; one request accepted every cycle.
//
// Ports:
//   clk, rst (sync active-low)
//   req_en/req_wr/req_addr/req_wdata - request, always accepted when req_en=1
//   rsp_valid/rsp_rdata/rsp_addr     - in-order read response (addr bit 0 = 0)
//   rd_pending                       - reads accepted but not yet retired
import mem_resp_pkg::*;

module mem_multicycle_resp #(
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int AWIDTH      = AWIDTH_DEF,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int LATENCY     = LATENCY_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_en,
  input  logic                         req_wr,
  input  logic [AWIDTH-1:0]            req_addr,
  input  logic [DWIDTH-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic [DWIDTH-1:0]            rsp_rdata,
  output logic [AWIDTH-1:0]            rsp_addr,
  output logic [$clog2(LATENCY+1)-1:0] rd_pending
);

  localparam int IW = idx_width(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY+1);

  typedef struct packed {
    logic              valid;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } rsp_stage_t;

  logic [DWIDTH-1:0] mem [DEPTH_WORDS];

  logic          wr_en;
  logic          rd_launch;
  logic          rd_retire;
  logic [IW-1:0] idx;
  rsp_stage_t    launch_stage;
  rsp_stage_t    out_stage;

  // Byte bit 0 and bits above the word index are intentionally dropped,
  // so addresses alias modulo the array size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[0], req_addr[AWIDTH-1:IW+1]};

  assign idx = req_addr[IW:1];

  // req_en gates everything first so X on the other request inputs is
  // harmless while idle; requests during reset are dropped.
  assign wr_en     = rst && req_en && req_wr;
  assign rd_launch = rst && req_en && !req_wr;

  // Array is deliberately not reset: contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= req_wdata;
    end
  end

  // The read samples the array before this edge's write (if any) lands,
  // so a read never sees a later write even while it is in flight.
  always_comb begin
    launch_stage       = '0;
    launch_stage.valid = rd_launch;
    launch_stage.addr  = {req_addr[AWIDTH-1:1], 1'b0};
    launch_stage.data  = mem[idx];
  end

  mem_rsp_pipe #(
    .LATENCY    (LATENCY),
    .stage_type (rsp_stage_t)
  ) u_pipe (
    .clk       (clk),
    .flush_n   (rst),
    .in_stage  (launch_stage),
    .out_stage (out_stage)
  );

  assign rsp_valid = out_stage.valid;
  assign rsp_rdata = out_stage.data;
  assign rsp_addr  = out_stage.addr;

  // A read retires at the edge that ends its response cycle.
  assign rd_retire = out_stage.valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_pending <= '0;
    end else if (rd_launch && !rd_retire) begin
      if (rd_pending != CW'(LATENCY)) begin
        rd_pending <= rd_pending + CW'(1);
      end
    end else if (!rd_launch && rd_retire) begin
      if (rd_pending != '0) begin
        rd_pending <= rd_pending - CW'(1);
      end
    end
  end

endmodule
